// File: rtl/mem_arbiter_if.sv
// Signal bundle between the core's IF/MEM ports, the arbiter and the shared memory bus.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface mem_arbiter_if;
   logic        if_req_valid;
   logic [63:0] if_req_addr;
   logic        if_req_ready;
   logic        if_resp_valid;
   logic [63:0] if_resp_data;
   logic        if_resp_err;

   logic        mem_req_valid;
   logic [63:0] mem_req_addr;
   logic        mem_req_wen;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_wmask;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_rdata;
   logic        mem_resp_err;

   logic        bus_req_valid;
   logic [63:0] bus_req_addr;
   logic        bus_req_wen;
   logic [63:0] bus_req_wdata;
   logic [7:0]  bus_req_wmask;
   logic        bus_req_ready;
   logic        bus_resp_valid;
   logic [63:0] bus_resp_rdata;

   modport slave (
      input  if_req_valid, if_req_addr,
      output if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
      input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
      output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
      output bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wmask,
      input  bus_req_ready, bus_resp_valid, bus_resp_rdata
   );

   modport master (
      output if_req_valid, if_req_addr,
      input  if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
      output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
      input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
      input  bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wmask,
      output bus_req_ready, bus_resp_valid, bus_resp_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master (IF, MEM) arbiter onto one 64-bit request/response bus, one transaction in flight,
// MEM priority with optional IF fairness and a response timeout that returns an error.
module mem_arbiter #(
   parameter bit          FAIR           = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic           clk,
   input logic           rst,
   mem_arbiter_if.slave  arb
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   typedef enum logic {OWN_IF, OWN_MEM} owner_t;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
   localparam bit         TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);

   state_t      state_reg;
   owner_t      owner_reg;
   owner_t      last_grant_reg;
   logic [7:0]  count_reg;
   logic [63:0] addr_reg;
   logic        wen_reg;
   logic [63:0] wdata_reg;
   logic [7:0]  wmask_reg;

   logic        idle;
   logic        busy;
   logic        grant_mem;
   logic        grant_if;
   logic        resp_hit;
   logic        timed_out;
   logic        resp_fire;
   logic [63:0] resp_data;

   // Grants are gated by rst so every ready output reads 0 while reset is held.
   assign idle      = (state_reg == IDLE) && rst;
   assign busy      = (state_reg != IDLE);
   assign grant_mem = idle && arb.mem_req_valid &&
                      !(FAIR && (last_grant_reg == OWN_MEM) && arb.if_req_valid);
   assign grant_if  = idle && arb.if_req_valid && !grant_mem;

   // A real response always beats a timeout landing in the same cycle.
   assign resp_hit  = (state_reg == WAIT) && arb.bus_resp_valid;
   assign timed_out = TIMEOUT_EN && busy && (count_reg == TIMEOUT_LIMIT);
   assign resp_fire = resp_hit || timed_out;
   assign resp_data = resp_hit ? arb.bus_resp_rdata : 64'd0;

   assign arb.if_req_ready   = grant_if;
   assign arb.mem_req_ready  = grant_mem;

   assign arb.if_resp_valid  = resp_fire && (owner_reg == OWN_IF);
   assign arb.if_resp_err    = timed_out && !resp_hit && (owner_reg == OWN_IF);
   assign arb.if_resp_data   = (owner_reg == OWN_IF) ? resp_data : 64'd0;

   assign arb.mem_resp_valid = resp_fire && (owner_reg == OWN_MEM);
   assign arb.mem_resp_err   = timed_out && !resp_hit && (owner_reg == OWN_MEM);
   assign arb.mem_resp_rdata = ((owner_reg == OWN_MEM) && !wen_reg) ? resp_data : 64'd0;

   assign arb.bus_req_valid  = (state_reg == REQ) && !timed_out;
   assign arb.bus_req_addr   = addr_reg;
   assign arb.bus_req_wen    = wen_reg;
   assign arb.bus_req_wdata  = wdata_reg;
   assign arb.bus_req_wmask  = wmask_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         owner_reg      <= OWN_IF;
         last_grant_reg <= OWN_IF;
         count_reg      <= 8'd0;
         addr_reg       <= 64'd0;
         wen_reg        <= 1'b0;
         wdata_reg      <= 64'd0;
         wmask_reg      <= 8'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (grant_mem) begin
                  state_reg      <= REQ;
                  owner_reg      <= OWN_MEM;
                  last_grant_reg <= OWN_MEM;
                  count_reg      <= 8'd0;
                  addr_reg       <= arb.mem_req_addr;
                  wen_reg        <= arb.mem_req_wen;
                  wdata_reg      <= arb.mem_req_wdata;
                  wmask_reg      <= arb.mem_req_wmask;
               end else if (grant_if) begin
                  state_reg      <= REQ;
                  owner_reg      <= OWN_IF;
                  last_grant_reg <= OWN_IF;
                  count_reg      <= 8'd0;
                  addr_reg       <= arb.if_req_addr;
                  wen_reg        <= 1'b0;
                  wdata_reg      <= 64'd0;
                  wmask_reg      <= 8'd0;
               end
            end
            REQ: begin
               if (timed_out) begin
                  state_reg <= IDLE;
               end else begin
                  count_reg <= count_reg + 8'd1;
                  if (arb.bus_req_ready) state_reg <= WAIT;
               end
            end
            WAIT: begin
               if (resp_fire) state_reg <= IDLE;
               else           count_reg <= count_reg + 8'd1;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed checking of mem_arbiter against a transaction-level reference model.
// Main DUT: FAIR=1, TIMEOUT_CYCLES=4; a FAIR=0 copy shares its inputs for the grant-order test.
module tb_mem_arbiter;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if a1 ();
   mem_arbiter_if a2 ();

   mem_arbiter #(.FAIR(1'b1), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .arb(a1)
   );
   mem_arbiter #(.FAIR(1'b0), .TIMEOUT_CYCLES(255)) dut_nofair (
      .clk(clk), .rst(rst), .arb(a2)
   );

   assign a2.if_req_valid   = a1.if_req_valid;
   assign a2.if_req_addr    = a1.if_req_addr;
   assign a2.mem_req_valid  = a1.mem_req_valid;
   assign a2.mem_req_addr   = a1.mem_req_addr;
   assign a2.mem_req_wen    = a1.mem_req_wen;
   assign a2.mem_req_wdata  = a1.mem_req_wdata;
   assign a2.mem_req_wmask  = a1.mem_req_wmask;
   assign a2.bus_req_ready  = a1.bus_req_ready;
   assign a2.bus_resp_valid = a1.bus_resp_valid;
   assign a2.bus_resp_rdata = a1.bus_resp_rdata;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the single outstanding transaction as a record in a queue.
   typedef struct {
      bit          is_mem;
      logic [63:0] addr;
      bit          wen;
      logic [63:0] wdata;
      logic [7:0]  wmask;
      bit          sent;
      int          age;
   } txn_t;

   txn_t q[$];
   bit   last_mem = 1'b0;
   bit   if_pend  = 1'b0;
   bit   mem_pend = 1'b0;
   bit   hold_reqs = 1'b0;
   int   n_txn = 0;

   task automatic quiet_inputs();
      a1.if_req_valid = 1'b0;  a1.if_req_addr = '0;
      a1.mem_req_valid = 1'b0; a1.mem_req_addr = '0; a1.mem_req_wen = 1'b0;
      a1.mem_req_wdata = '0;   a1.mem_req_wmask = '0;
      a1.bus_req_ready = 1'b0; a1.bus_resp_valid = 1'b0; a1.bus_resp_rdata = '0;
      if_pend = 1'b0; mem_pend = 1'b0;
   endtask

   task automatic req_if(input logic [63:0] addr);
      a1.if_req_valid = 1'b1; a1.if_req_addr = addr; if_pend = 1'b1;
   endtask

   task automatic req_mem(input logic [63:0] addr, input bit wen,
                          input logic [63:0] wdata, input logic [7:0] wmask);
      a1.mem_req_valid = 1'b1; a1.mem_req_addr = addr; a1.mem_req_wen = wen;
      a1.mem_req_wdata = wdata; a1.mem_req_wmask = wmask; mem_pend = 1'b1;
   endtask

   task automatic bus(input bit rdy, input bit rv, input logic [63:0] rd);
      a1.bus_req_ready = rdy; a1.bus_resp_valid = rv; a1.bus_resp_rdata = rd;
   endtask

   // Compare every master-visible and bus-visible output with the model's prediction.
   task automatic sample();
      #2;
      if (q.size() == 0) begin
         bit gm, gi;
         gm = a1.mem_req_valid && !(last_mem && a1.if_req_valid);
         gi = a1.if_req_valid && !gm;
         check("if_req_ready", a1.if_req_ready, gi);
         check("mem_req_ready", a1.mem_req_ready, gm);
         check("bus_req_valid_idle", a1.bus_req_valid, 0);
         check("if_resp_valid_idle", a1.if_resp_valid, 0);
         check("mem_resp_valid_idle", a1.mem_resp_valid, 0);
      end else begin
         txn_t t;
         bit to, rsp, fire;
         logic [63:0] exp_data;
         t    = q[0];
         to   = (t.age >= TO);
         rsp  = t.sent && a1.bus_resp_valid;
         fire = rsp || to;
         check("if_req_ready_busy", a1.if_req_ready, 0);
         check("mem_req_ready_busy", a1.mem_req_ready, 0);
         check("bus_req_valid", a1.bus_req_valid, !t.sent && !to);
         if (!t.sent && !to) begin
            check("bus_req_addr", a1.bus_req_addr, t.addr);
            check("bus_req_wen", a1.bus_req_wen, t.wen);
            check("bus_req_wdata", a1.bus_req_wdata, t.wdata);
            check("bus_req_wmask", a1.bus_req_wmask, t.wmask);
         end
         exp_data = (rsp && !(t.is_mem && t.wen)) ? a1.bus_resp_rdata : 64'd0;
         check("if_resp_valid", a1.if_resp_valid, fire && !t.is_mem);
         check("mem_resp_valid", a1.mem_resp_valid, fire && t.is_mem);
         if (fire && !t.is_mem) begin
            check("if_resp_data", a1.if_resp_data, exp_data);
            check("if_resp_err", a1.if_resp_err, !rsp);
         end
         if (fire && t.is_mem) begin
            check("mem_resp_rdata", a1.mem_resp_rdata, exp_data);
            check("mem_resp_err", a1.mem_resp_err, !rsp);
         end
      end
   endtask

   // Advance the model across the coming edge, then retire granted requests.
   task automatic tick();
      bit if_taken, mem_taken;
      if_taken = 1'b0; mem_taken = 1'b0;
      if (q.size() == 0) begin
         txn_t t;
         t.sent = 1'b0; t.age = 0;
         if (a1.mem_req_valid && !(last_mem && a1.if_req_valid)) begin
            t.is_mem = 1'b1; t.addr = a1.mem_req_addr; t.wen = a1.mem_req_wen;
            t.wdata = a1.mem_req_wdata; t.wmask = a1.mem_req_wmask;
            q.push_back(t); last_mem = 1'b1; mem_taken = 1'b1;
         end else if (a1.if_req_valid) begin
            t.is_mem = 1'b0; t.addr = a1.if_req_addr; t.wen = 1'b0;
            t.wdata = '0; t.wmask = '0;
            q.push_back(t); last_mem = 1'b0; if_taken = 1'b1;
         end
      end else begin
         txn_t t;
         bit rsp, to;
         t   = q[0];
         to  = (t.age >= TO);
         rsp = t.sent && a1.bus_resp_valid;
         if (rsp || to) begin
            n_txn++;
            $display("txn %0d %s %s addr=%h %s", n_txn, t.is_mem ? "MEM" : "IF ",
                     t.wen ? "wr" : "rd", t.addr, rsp ? "resp" : "timeout");
            void'(q.pop_front());
         end else begin
            if (a1.bus_req_ready) t.sent = 1'b1;
            t.age++;
            q[0] = t;
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (!hold_reqs && if_taken)  begin a1.if_req_valid = 1'b0;  if_pend = 1'b0;  end
      if (!hold_reqs && mem_taken) begin a1.mem_req_valid = 1'b0; mem_pend = 1'b0; end
   endtask

   task automatic cycle();
      sample();
      tick();
   endtask

   // Assert reset asynchronously at the current time and check outputs clear before any edge.
   task automatic do_reset();
      quiet_inputs();
      rst = 1'b0;
      #1;
      check("rst_if_req_ready", a1.if_req_ready, 0);
      check("rst_mem_req_ready", a1.mem_req_ready, 0);
      check("rst_resp_valids", {a1.if_resp_valid, a1.mem_resp_valid}, 0);
      check("rst_resp_errs", {a1.if_resp_err, a1.mem_resp_err}, 0);
      check("rst_bus_req_valid", a1.bus_req_valid, 0);
      check("rst_bus_req_addr", a1.bus_req_addr, 0);
      check("rst_bus_req_wdata", a1.bus_req_wdata, 0);
      check("rst_bus_req_wen_wmask", {a1.bus_req_wen, a1.bus_req_wmask}, 0);
      q.delete();
      last_mem = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus(1'b0, 1'b0, '0);
         cycle();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      quiet_inputs();
      @(negedge clk);
      do_reset();

      // IF read, immediate bus ready, response one cycle later.
      req_if(64'h8000_0000); bus(1'b0, 1'b0, '0);
      sample(); check("t1_if_ready_c0", a1.if_req_ready, 1); tick();
      bus(1'b1, 1'b0, '0);
      sample(); check("t1_bus_addr_c1", a1.bus_req_addr, 64'h8000_0000); tick();
      bus(1'b0, 1'b1, 64'h0000_0013_0000_0297);
      sample(); check("t1_if_data_c2", a1.if_resp_data, 64'h0000_0013_0000_0297); tick();
      idle(1);

      // MEM write held 3 cycles by the bus, response coincides with the timeout.
      req_mem(64'h8000_1000, 1'b1, 64'h1122_3344_5566_7788, 8'h0F);
      cycle();
      for (int i = 0; i < 3; i++) begin bus(1'b0, 1'b0, '0); cycle(); end
      bus(1'b1, 1'b0, '0); cycle();
      bus(1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001);
      sample(); check("t2_mem_wr_rdata", a1.mem_resp_rdata, 0); tick();
      idle(1);

      // MEM read: response and timeout in the same cycle passes data through with err=0.
      req_mem(64'h8000_2000, 1'b0, '0, '0);
      cycle();
      for (int i = 0; i < 3; i++) begin bus(1'b0, 1'b0, '0); cycle(); end
      bus(1'b1, 1'b0, '0); cycle();
      bus(1'b0, 1'b1, 64'h0123_4567_89AB_CDEF);
      sample(); check("t3_rd_err", a1.mem_resp_err, 0); tick();
      idle(1);

      // Simultaneous requests held over two transactions: grant order differs with FAIR.
      do_reset();
      hold_reqs = 1'b1;
      req_if(64'h1000); req_mem(64'h2000, 1'b0, '0, '0); bus(1'b0, 1'b0, '0);
      sample(); check("t4_fair_first_mem", a1.mem_req_ready, 1);
      check("t4_nofair_first_mem", a2.mem_req_ready, 1); tick();
      bus(1'b1, 1'b0, '0); cycle();
      bus(1'b0, 1'b1, 64'h55); cycle();
      bus(1'b0, 1'b0, '0);
      sample(); check("t4_fair_second_if", a1.if_req_ready, 1);
      check("t4_nofair_second_mem", {a2.if_req_ready, a2.mem_req_ready}, 2'b01);
      hold_reqs = 1'b0; tick();
      a1.mem_req_valid = 1'b0; mem_pend = 1'b0;
      bus(1'b1, 1'b0, '0); cycle();
      bus(1'b0, 1'b1, 64'h66); cycle();
      idle(1);

      // Bus never answers: error after TO cycles in REQ, later stray response ignored.
      req_if(64'h3000); cycle();
      for (int i = 0; i < TO; i++) begin bus(1'b0, 1'b0, '0); cycle(); end
      sample(); check("t5_timeout_err", a1.if_resp_err, 1);
      check("t5_timeout_data", a1.if_resp_data, 0); tick();
      bus(1'b0, 1'b1, 64'h77);
      sample(); check("t5_stray_ignored", a1.if_resp_valid, 0); tick();
      idle(1);

      // Reset while waiting for a response, then a stray response, then a normal IF read.
      req_if(64'h4000); cycle();
      bus(1'b1, 1'b0, '0); cycle();
      bus(1'b0, 1'b0, '0); sample();
      do_reset();
      bus(1'b0, 1'b1, 64'h88); cycle();
      req_if(64'h5000); bus(1'b0, 1'b0, '0); cycle();
      bus(1'b1, 1'b0, '0); cycle();
      bus(1'b0, 1'b1, 64'h99);
      sample(); check("t6_after_rst_data", a1.if_resp_data, 64'h99); tick();
      idle(1);

      // Random traffic from both masters against a randomly stalling bus.
      for (int n = 0; n < 400; n++) begin
         if (!if_pend && $urandom_range(0, 2) == 0)
            req_if({$urandom, $urandom});
         if (!mem_pend && $urandom_range(0, 2) == 0)
            req_mem({$urandom, $urandom}, 1'($urandom_range(0, 1)),
                    {$urandom, $urandom}, 8'($urandom));
         bus(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), {$urandom, $urandom});
         cycle();
      end
      a1.if_req_valid = 1'b0; a1.mem_req_valid = 1'b0; if_pend = 1'b0; mem_pend = 1'b0;
      for (int n = 0; n < 20 && q.size() != 0; n++) begin
         bus(1'b1, 1'b1, {$urandom, $urandom});
         cycle();
      end
      check("drain_empty", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
